codon_sequencer: RTL and testbench
==================================

Name: codon_sequencer

Overview:
- Sequencing controller for the codon counting datapath.
- Holds up to NUM_CODONS search patterns loaded over a config handshake, and serves pattern nibbles to the counter as codon1..codon5 and end_of_codon, indexed by the counter's codon_index.
- Resets and releases the counter, waits for done_counter, then walks count_index over every codon and streams the (codon, count) results out on a valid/ready handshake.

Parameters:
- NUM_CODONS, 5, number of pattern slots; fixed at 5 to match the codon1..codon5 ports.
- MAX_LEN, 8, maximum nibbles per pattern.
- IDX_W, 3, width of codon_index, equal to clog2(MAX_LEN).
- COUNT_W, 4, width of a per-codon count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config nibble valid.
- cfg_ready  out  1  config accepted; high only in IDLE.
- cfg_codon  in  3  target slot, 0..4.
- cfg_nibble  in  4  pattern nibble; 0xF is illegal.
- cfg_last  in  1  this nibble closes the pattern.
- start  in  1  launch a counting run; sampled in IDLE only.
- ctr_reset  out  1  synchronous active-high reset to the counter.
- done_reader  out  1  tells the counter the genome is ready.
- codon_index  in  IDX_W  nibble index requested by the counter.
- codon1..codon5  out  4 each  pattern nibble at codon_index, or 0xF.
- end_of_codon  out  5  bit i set when codon_index is the last nibble of slot i.
- done_counter  in  1  counter finished.
- count_index  out  3  counter count select, 0-based.
- codon_count  in  COUNT_W  counter count at count_index.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_codon  out  3  slot of the current result.
- res_count  out  COUNT_W  count of the current result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last result is accepted.
- err  out  1  sticky config/start error.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all pattern storage and lengths cleared.
  - ctr_reset=0, done_reader=0, res_valid=0, count_index=0, res_codon=0, res_count=0, done=0, err=0.
- Storage: len[i] (0..MAX_LEN) and pat[i][0..MAX_LEN-1].
- Config, accepted when cfg_valid&&cfg_ready:
  - The nibble is written at wptr[cfg_codon], then wptr increments.
  - cfg_last closes the slot: len=wptr+1, wptr=0.
  - A write to a closed slot reopens it: len=0, then writes from index 0.
  - cfg_nibble==0xF, cfg_codon>4, or a write beyond MAX_LEN: nibble dropped, err=1.
- Pattern outputs (combinational from codon_index and storage):
  - codonN = pat[N-1][codon_index] when codon_index < len[N-1]; otherwise 0xF.
  - end_of_codon[i] = (len[i]!=0) && (codon_index==len[i]-1).
  - An empty slot outputs 0xF at every index and never matches.
- FSM:
  - IDLE: cfg_ready=1.
    - start with at least one len!=0 and no slot open mid-load -> ARM.
    - start with all lengths zero, or a slot open mid-load -> err=1, stay IDLE.
  - ARM: ctr_reset=1 for exactly one cycle -> RUN.
  - RUN: done_reader=1 held every cycle; done_counter=1 -> COLLECT with i=0.
  - COLLECT: count_index=i for one cycle; at the edge, res_count<=codon_count and res_codon<=i -> PRESENT.
  - PRESENT: res_valid=1; res_count and res_codon are stable until handshake.
    - res_valid&&res_ready with i<4 -> i++, -> COLLECT.
    - With i==4 -> done pulse, -> IDLE.
- Latency:
  - start to ctr_reset: 1 cycle. Counter released the cycle after.
  - done_counter to first res_valid: 2 cycles.
  - Back-to-back results: 2 cycles each with res_ready tied high.
- Boundary conditions:
  - start outside IDLE is ignored. cfg_valid outside IDLE is not accepted (cfg_ready=0).
  - done_counter outside RUN is ignored.
  - Patterns persist across runs; err is cleared only by reset.
  - Reset mid-run: immediate return to IDLE with patterns erased.

Optional Feature:
- Macro: CODON_TOTAL_EN.
- When defined:
  - After slot 4 is accepted, a sixth result is presented with res_codon=5 and res_count=the saturating sum of the five counts (COUNT_W bits, clamps at all-ones).
  - The done pulse follows acceptance of this sixth result.
- When undefined: five results only; no accumulator logic exists.

Test Plan:
- Load slot0={A,C}, slot1={3}, others empty; start; model counter returns counts {2,5,0,0,0} -> ctr_reset one cycle, done_reader until done_counter; results (0,2),(1,5),(2,0),(3,0),(4,0); done pulse.
- With slot0={A,C} loaded: codon_index 0 -> codon1=A, end_of_codon=00000; codon_index 1 -> codon1=C, end_of_codon[0]=1; codon_index 2 -> codon1=F; empty slots -> F.
- cfg_nibble=F, then 9 nibbles into one slot -> both offending writes dropped, err=1, len=8; start with no patterns -> err=1, busy stays 0.
- res_ready held low 10 cycles in PRESENT -> res_valid, res_codon and res_count stable; release -> next result 2 cycles later.
- Assert reset in RUN -> all outputs at reset values asynchronously; start after config-free reset -> err=1.
- CODON_TOTAL_EN with counts {9,9,0,0,1} -> sixth result (5,15) saturated, then done.

Source files
------------

// File: rtl/codon_sequencer_if.sv
`timescale 1ns/1ps
// codon_sequencer_if: config-load and result-stream handshakes of the codon sequencer.
// The master side loads pattern nibbles and consumes results; the slave side is the sequencer.
interface codon_sequencer_if #(
    parameter int COUNT_W = 4
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_codon;
    logic [3:0]         cfg_nibble;
    logic               cfg_last;
    logic               res_valid;
    logic               res_ready;
    logic [2:0]         res_codon;
    logic [COUNT_W-1:0] res_count;

    modport master (
        output cfg_valid, cfg_codon, cfg_nibble, cfg_last, res_ready,
        input  cfg_ready, res_valid, res_codon, res_count
    );

    modport slave (
        input  cfg_valid, cfg_codon, cfg_nibble, cfg_last, res_ready,
        output cfg_ready, res_valid, res_codon, res_count
    );
endinterface

// File: rtl/codon_sequencer.sv
`timescale 1ns/1ps
// codon_sequencer: stores up to five search patterns, serves their nibbles to the
// codon counter, runs one counting pass and streams out the per-slot counts.
// Build macro CODON_TOTAL_EN appends a sixth result carrying the saturated sum
// of the five counts (res_codon = 5).
module codon_sequencer #(
    parameter int NUM_CODONS = 5,
    parameter int MAX_LEN    = 8,
    parameter int IDX_W      = 3,
    parameter int COUNT_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    codon_sequencer_if.slave      bus,
    input  logic                  start,
    output logic                  ctr_reset,
    output logic                  done_reader,
    input  logic [IDX_W-1:0]      codon_index,
    output logic [3:0]            codon1,
    output logic [3:0]            codon2,
    output logic [3:0]            codon3,
    output logic [3:0]            codon4,
    output logic [3:0]            codon5,
    output logic [NUM_CODONS-1:0] end_of_codon,
    input  logic                  done_counter,
    output logic [2:0]            count_index,
    input  logic [COUNT_W-1:0]    codon_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
`ifdef CODON_TOTAL_EN
    localparam logic [2:0] LAST_IDX = 3'(NUM_CODONS);
`else
    localparam logic [2:0] LAST_IDX = 3'(NUM_CODONS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_COLLECT,
        S_PRESENT
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           pat_q  [NUM_CODONS][MAX_LEN];
    logic [3:0]           pat_d  [NUM_CODONS][MAX_LEN];
    logic [LEN_W-1:0]     len_q  [NUM_CODONS];
    logic [LEN_W-1:0]     len_d  [NUM_CODONS];
    logic [LEN_W-1:0]     wptr_q [NUM_CODONS];
    logic [LEN_W-1:0]     wptr_d [NUM_CODONS];
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           res_codon_q, res_codon_d;
    logic [COUNT_W-1:0]   res_count_q, res_count_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 cfg_fire;
    logic                 cfg_err;
    logic                 start_err;
    logic                 any_loaded;
    logic                 any_open;
    logic [3:0]           nib [NUM_CODONS];
`ifdef CODON_TOTAL_EN
    logic [COUNT_W-1:0]   sum_q, sum_d;
    logic [COUNT_W:0]     sum_ext;

    assign sum_ext = {1'b0, sum_q} + {1'b0, codon_count};
`endif

    assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
    assign bus.cfg_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_PRESENT);
    assign bus.res_codon = res_codon_q;
    assign bus.res_count = res_count_q;
    assign ctr_reset     = (state_q == S_ARM);
    assign done_reader   = (state_q == S_RUN);
    assign busy          = (state_q != S_IDLE);
    assign count_index   = idx_q;
    assign done          = done_q;
    assign err           = err_q;

    // Summarise slot status for the start check: something closed, nothing half-loaded.
    always_comb begin
        any_loaded = 1'b0;
        any_open   = 1'b0;
        for (int s = 0; s < NUM_CODONS; s++) begin
            any_loaded = any_loaded | (len_q[s] != '0);
            any_open   = any_open | (wptr_q[s] != '0);
        end
    end

    // Pattern loading: append at the slot's write pointer; a dropped nibble that
    // carries cfg_last still closes a half-loaded slot with what it holds so far.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        cfg_err = 1'b0;
        if (cfg_fire && (int'(bus.cfg_codon) >= NUM_CODONS)) begin
            cfg_err = 1'b1;
        end
        for (int s = 0; s < NUM_CODONS; s++) begin
            if (cfg_fire && (int'(bus.cfg_codon) == s)) begin
                if ((bus.cfg_nibble == 4'hF) || (wptr_q[s] == LEN_W'(MAX_LEN))) begin
                    cfg_err = 1'b1;
                    if (bus.cfg_last && (wptr_q[s] != '0)) begin
                        len_d[s]  = wptr_q[s];
                        wptr_d[s] = '0;
                    end
                end else begin
                    pat_d[s][wptr_q[s][IDX_W-1:0]] = bus.cfg_nibble;
                    if (wptr_q[s] == '0) begin
                        len_d[s] = '0;
                    end
                    if (bus.cfg_last) begin
                        len_d[s]  = wptr_q[s] + LEN_W'(1);
                        wptr_d[s] = '0;
                    end else begin
                        wptr_d[s] = wptr_q[s] + LEN_W'(1);
                    end
                end
            end
        end
    end

    // Nibble lookup for the counter; indices past a slot's length read as 0xF.
    always_comb begin
        end_of_codon = '0;
        for (int s = 0; s < NUM_CODONS; s++) begin
            if (LEN_W'(codon_index) < len_q[s]) begin
                nib[s] = pat_q[s][codon_index];
            end else begin
                nib[s] = 4'hF;
            end
            end_of_codon[s] = (len_q[s] != '0) && (LEN_W'(codon_index) == (len_q[s] - LEN_W'(1)));
        end
    end

    assign codon1 = nib[0];
    assign codon2 = nib[1];
    assign codon3 = nib[2];
    assign codon4 = nib[3];
    assign codon5 = nib[4];

    // Run sequencing: arm the counter, wait for it, then fetch and present each count.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        res_codon_d = res_codon_q;
        res_count_d = res_count_q;
        done_d      = 1'b0;
        start_err   = 1'b0;
`ifdef CODON_TOTAL_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (any_loaded && !any_open) begin
                        state_d = S_ARM;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (done_counter) begin
                    state_d = S_COLLECT;
                    idx_d   = '0;
`ifdef CODON_TOTAL_EN
                    sum_d   = '0;
`endif
                end
            end
            S_COLLECT: begin
                res_codon_d = idx_q;
`ifdef CODON_TOTAL_EN
                if (idx_q == LAST_IDX) begin
                    res_count_d = sum_q;
                end else begin
                    res_count_d = codon_count;
                    sum_d       = sum_ext[COUNT_W] ? '1 : sum_ext[COUNT_W-1:0];
                end
`else
                res_count_d = codon_count;
`endif
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.res_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_COLLECT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        err_d = err_q | cfg_err | start_err;
    end

    // Control and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            res_codon_q <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CODON_TOTAL_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            res_codon_q <= res_codon_d;
            res_count_q <= res_count_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CODON_TOTAL_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Pattern storage; reset erases every slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_CODONS; s++) begin
                len_q[s]  <= '0;
                wptr_q[s] <= '0;
                for (int j = 0; j < MAX_LEN; j++) begin
                    pat_q[s][j] <= '0;
                end
            end
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            wptr_q <= wptr_d;
        end
    end
endmodule

// File: tb/tb_codon_sequencer.sv
`timescale 1ns/1ps
// tb_codon_sequencer: randomized bench with a pattern-store reference model, a
// counter model and a result scoreboard drained by an independent monitor.
module tb_codon_sequencer;
    typedef struct packed {
        logic [2:0] codon;
        logic [3:0] count;
        logic       last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        done_counter = 1'b0;
    logic [2:0]  codon_index = '0;
    logic [3:0]  codon_count;
    logic        ctr_reset, done_reader, busy, done, err;
    logic [3:0]  codon1, codon2, codon3, codon4, codon5;
    logic [4:0]  end_of_codon;
    logic [2:0]  count_index;
    logic [3:0]  codon_vec [5];
    logic [3:0]  tb_counts [8];

    int          n_checks = 0;
    int          n_errors = 0;
    int          ready_policy = 0;
    bit          expect_done = 1'b0;
    exp_t        sb [$];

    logic [3:0]  m_pat  [5][8];
    logic [3:0]  m_load [5][8];
    int          m_len  [5];
    int          m_lcnt [5];
    bit          m_err;

    codon_sequencer_if #(.COUNT_W(4)) bus ();

    codon_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .start        (start),
        .ctr_reset    (ctr_reset),
        .done_reader  (done_reader),
        .codon_index  (codon_index),
        .codon1       (codon1),
        .codon2       (codon2),
        .codon3       (codon3),
        .codon4       (codon4),
        .codon5       (codon5),
        .end_of_codon (end_of_codon),
        .done_counter (done_counter),
        .count_index  (count_index),
        .codon_count  (codon_count),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    assign codon_vec[0] = codon1;
    assign codon_vec[1] = codon2;
    assign codon_vec[2] = codon3;
    assign codon_vec[3] = codon4;
    assign codon_vec[4] = codon5;
    assign codon_count  = tb_counts[count_index];

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Result consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clock) begin
        #1;
        case (ready_policy)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = 1'($urandom_range(0, 1));
            default: bus.res_ready = 1'b0;
        endcase
    end

    // Monitor: every presented result must match the scoreboard head until accepted.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (expect_done) begin
                check_output("done_pulse", 32'(done), 32'd1);
                expect_done = 1'b0;
            end
            if (bus.res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_result", 32'(bus.res_valid), 32'd0);
                end else begin
                    check_output("res_codon", 32'(bus.res_codon), 32'(sb[0].codon));
                    check_output("res_count", 32'(bus.res_count), 32'(sb[0].count));
                    if (bus.res_ready === 1'b1) begin
                        e = sb.pop_front();
                        if (e.last) expect_done = 1'b1;
                    end
                end
            end
        end
    end

    function automatic void model_clear();
        for (int s = 0; s < 5; s++) begin
            m_len[s]  = 0;
            m_lcnt[s] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_commit(input int s);
        for (int j = 0; j < 8; j++) m_pat[s][j] = m_load[s][j];
        m_len[s]  = m_lcnt[s];
        m_lcnt[s] = 0;
    endfunction

    function automatic void model_write(input int s, input logic [3:0] nib, input bit last);
        if (s > 4) begin
            m_err = 1'b1;
        end else if (nib == 4'hF || m_lcnt[s] == 8) begin
            m_err = 1'b1;
            if (last && m_lcnt[s] != 0) model_commit(s);
        end else begin
            if (m_lcnt[s] == 0) m_len[s] = 0;
            m_load[s][m_lcnt[s]] = nib;
            m_lcnt[s]++;
            if (last) model_commit(s);
        end
    endfunction

    function automatic bit model_start();
        bit loaded = 1'b0;
        bit open = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (m_len[s] != 0) loaded = 1'b1;
            if (m_lcnt[s] != 0) open = 1'b1;
        end
        if (!loaded || open) m_err = 1'b1;
        return loaded && !open;
    endfunction

    task automatic cfg_write(input int s, input logic [3:0] nib, input bit last);
        @(posedge clock); #1;
        bus.cfg_valid  = 1'b1;
        bus.cfg_codon  = 3'(s);
        bus.cfg_nibble = nib;
        bus.cfg_last   = last;
        @(posedge clock); #1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_last   = 1'b0;
        model_write(s, nib, last);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic check_reset_state();
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check_output("rst_ctr_reset", 32'(ctr_reset), 32'd0);
        check_output("rst_done_reader", 32'(done_reader), 32'd0);
        check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_output("rst_res_codon", 32'(bus.res_codon), 32'd0);
        check_output("rst_res_count", 32'(bus.res_count), 32'd0);
        check_output("rst_count_index", 32'(count_index), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_codon1", 32'(codon1), 32'hF);
        check_output("rst_end_of_codon", 32'(end_of_codon), 32'd0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check_reset_state();
        model_clear();
        sb.delete();
        expect_done = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
    endtask

    // Sweep every codon_index and compare the served nibbles with the stored patterns.
    task automatic check_patterns();
        logic [4:0] exp_eoc;
        for (int idx = 0; idx < 8; idx++) begin
            @(posedge clock); #1 codon_index = 3'(idx);
            @(negedge clock);
            exp_eoc = '0;
            for (int s = 0; s < 5; s++) begin
                check_output($sformatf("codon%0d_idx%0d", s + 1, idx), 32'(codon_vec[s]),
                             32'((idx < m_len[s]) ? m_pat[s][idx] : 4'hF));
                exp_eoc[s] = (m_len[s] != 0) && (idx == m_len[s] - 1);
            end
            check_output($sformatf("end_of_codon_idx%0d", idx), 32'(end_of_codon), 32'(exp_eoc));
        end
    endtask

    // One full counting run with counts cv (slot i in cv[4i+3:4i]).
    task automatic apply_stimulus(input logic [19:0] cv, input int dc_delay, input bit hold);
        exp_t e;
        int   sum;
        int   t;
        bit   ok;
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            tb_counts[i] = cv[i*4 +: 4];
            sum += int'(cv[i*4 +: 4]);
            e.codon = 3'(i);
            e.count = cv[i*4 +: 4];
`ifdef CODON_TOTAL_EN
            e.last  = 1'b0;
`else
            e.last  = (i == 4);
`endif
            sb.push_back(e);
        end
`ifdef CODON_TOTAL_EN
        e.codon = 3'd5;
        e.count = (sum > 15) ? 4'hF : 4'(sum);
        e.last  = 1'b1;
        sb.push_back(e);
`endif
        ok = model_start();
        if (!ok) $display("[TB] note: run requested without a legal pattern set");
        pulse_start();
        @(negedge clock);
        check_output("arm_ctr_reset", 32'(ctr_reset), 32'd1);
        check_output("arm_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check_output("run_ctr_reset", 32'(ctr_reset), 32'd0);
        check_output("run_done_reader", 32'(done_reader), 32'd1);
        check_output("run_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        repeat (dc_delay) @(posedge clock);
        #1;
        done_counter   = 1'b1;
        start          = 1'b1;
        bus.cfg_valid  = 1'b1;
        bus.cfg_codon  = 3'd0;
        bus.cfg_nibble = 4'h1;
        bus.cfg_last   = 1'b1;
        @(posedge clock); #1;
        done_counter   = 1'b0;
        start          = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_last   = 1'b0;
        @(negedge clock);
        check_output("collect_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clock);
        check_output("first_res_valid", 32'(bus.res_valid), 32'd1);
        if (hold) begin
            repeat (10) begin
                @(negedge clock);
                check_output("hold_res_valid", 32'(bus.res_valid), 32'd1);
            end
            ready_policy = 0;
            @(negedge clock);
            @(negedge clock);
            check_output("release_gap", 32'(bus.res_valid), 32'd0);
            @(negedge clock);
            check_output("release_next_valid", 32'(bus.res_valid), 32'd1);
        end
        t = 0;
        while (t < 200) begin
            @(negedge clock);
            t++;
            if (done === 1'b1) break;
        end
        check_output("done_seen", 32'(done), 32'd1);
        check_output("results_drained", 32'(sb.size()), 32'd0);
        @(negedge clock);
        check_output("done_one_cycle", 32'(done), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);
        check_output("run_err", 32'(err), 32'(m_err));
    endtask

    // Start attempt that must be refused: err raised, sequencer stays idle.
    task automatic expect_start_refused(input string name);
        bit ok;
        ok = model_start();
        pulse_start();
        @(negedge clock);
        check_output({name, "_busy"}, 32'(busy), 32'd0);
        check_output({name, "_ctr_reset"}, 32'(ctr_reset), 32'd0);
        check_output({name, "_err"}, 32'(err), 32'(m_err));
        if (ok) $display("[TB] note: %s expected a refused start", name);
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_codon  = '0;
        bus.cfg_nibble = '0;
        bus.cfg_last   = 1'b0;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 8; i++) tb_counts[i] = '0;
        model_clear();
        repeat (2) @(posedge clock);
        do_reset();

        $display("[TB] directed run: slot0={A,C}, slot1={3}");
        cfg_write(0, 4'hA, 1'b0);
        cfg_write(0, 4'hC, 1'b1);
        cfg_write(1, 4'h3, 1'b1);
        check_patterns();
        apply_stimulus({4'd0, 4'd0, 4'd0, 4'd5, 4'd2}, 3, 1'b0);
        check_patterns();

        $display("[TB] randomized runs");
        ready_policy = 1;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 5; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int n;
                    n = $urandom_range(1, 8);
                    for (int j = 0; j < n; j++) cfg_write(s, 4'($urandom_range(0, 14)), j == n - 1);
                end
            end
            check_patterns();
            apply_stimulus(20'($urandom), $urandom_range(1, 6), 1'b0);
        end

        $display("[TB] stalled consumer");
        ready_policy = 2;
        apply_stimulus(20'($urandom), 2, 1'b1);

        $display("[TB] done_counter while idle");
        @(posedge clock); #1 done_counter = 1'b1;
        @(posedge clock); #1 done_counter = 1'b0;
        @(negedge clock);
        check_output("idle_done_counter_busy", 32'(busy), 32'd0);
        check_output("idle_done_counter_valid", 32'(bus.res_valid), 32'd0);

        $display("[TB] saturating-total counts");
        ready_policy = 0;
        apply_stimulus({4'd1, 4'd0, 4'd0, 4'd9, 4'd9}, 2, 1'b0);

        $display("[TB] start with a slot open mid-load");
        do_reset();
        cfg_write(1, 4'h5, 1'b0);
        cfg_write(1, 4'h6, 1'b1);
        cfg_write(0, 4'h7, 1'b0);
        expect_start_refused("open_slot");

        $display("[TB] illegal nibble");
        do_reset();
        cfg_write(2, 4'hF, 1'b1);
        @(negedge clock);
        check_output("bad_nibble_err", 32'(err), 32'(m_err));
        check_patterns();

        $display("[TB] overflow and bad slot");
        do_reset();
        for (int j = 0; j < 9; j++) cfg_write(3, 4'(j + 1), j == 8);
        @(negedge clock);
        check_output("overflow_err", 32'(err), 32'(m_err));
        check_patterns();
        cfg_write(6, 4'h2, 1'b1);
        apply_stimulus(20'($urandom), 4, 1'b0);

        $display("[TB] reset during run");
        tb_counts[0] = 4'd3;
        pulse_start();
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_reset_state();
        model_clear();
        sb.delete();
        expect_done = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        check_patterns();
        expect_start_refused("empty_start");

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
